byte_serial_logic_unit: RTL

- Multi-cycle front end for the ALU logic path. Accepts WIDTH-bit operands with a valid/ready handshake.
- Drives them one byte per cycle through a single 8-bit logic slice (AND/OR/XOR/NOR per byte) and assembles the full result.
- Presents the result with a zero flag on an output valid/ready handshake.
- Sits between the operand-issue stage and the ALU result mux; the 8-bit slice is consumed internally.

---
 rtl/byte_serial_logic_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/byte_serial_logic_unit.sv
// Byte-serial bitwise logic unit: latches two WIDTH-bit operands, runs them one byte per
// cycle through a shared 8-bit AND/OR/XOR/NOR slice, and hands back the result with a zero flag.
module byte_serial_logic_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             is_zero
);

    localparam int NB = WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             nz_q, nz_d;

    logic [7:0] a_bytes [NB];
    logic [7:0] b_bytes [NB];
    logic [7:0] a_byte, b_byte, slice_byte;

    for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
        assign a_bytes[gi] = a_q[8*gi +: 8];
        assign b_bytes[gi] = b_q[8*gi +: 8];
    end

    // The single shared 8-bit slice, fed by the byte the counter selects.
    always_comb begin
        a_byte = a_bytes[cnt_q];
        b_byte = b_bytes[cnt_q];
        case (op_q)
            2'b00:   slice_byte = a_byte & b_byte;
            2'b01:   slice_byte = a_byte | b_byte;
            2'b10:   slice_byte = a_byte ^ b_byte;
            default: slice_byte = ~(a_byte | b_byte);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        nz_d     = nz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = operand_a;
                    b_d      = operand_b;
                    op_d     = op;
                    result_d = '0;
                    cnt_d    = '0;
                    nz_d     = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NB; i++) begin
                    if (cnt_q == CW'(i)) result_d[8*i +: 8] = slice_byte;
                end
                nz_d = nz_q | (|slice_byte);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Result stays held after the handshake until the next accept clears it.
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            nz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            nz_q     <= nz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign is_zero   = ~nz_q;

endmodule
